seq_mul_div: RTL
================

Name: seq_mul_div

Overview:
- Iterative 32-bit multiply/divide unit for the CPU execute stage.
- Sits directly upstream of the result selector: it produces the two 64-bit operands that the selector splits into upper and lower words, using {hi, lo} word order.
- Multiply result is {product[63:32], product[31:0]}. Divide result is {remainder, quotient}.
- One operation at a time, with a start/busy/done handshake. Results are held until the next operation of the same class completes.

Parameters:
- DATA_W, 32, operand width; results are 2*DATA_W bits.
- ITER, DATA_W, number of iteration cycles; must equal DATA_W.

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  reset; synchronous, active-high
- start  in  1  request a new operation; sampled only when busy=0
- op  in  2  operation code; see package constants
- src_a  in  DATA_W  multiplicand / dividend
- src_b  in  DATA_W  multiplier / divisor
- busy  out  1  operation in progress; start ignored while high
- done  out  1  one-cycle pulse; new result valid in this cycle
- mul_result  out  2*DATA_W  {hi, lo} of last completed MULT/MULTU
- div_result  out  2*DATA_W  {remainder, quotient} of last completed DIV/DIVU

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; busy=0, done=0, mul_result=0, div_result=0; the iteration counter is cleared.
  - Reset overrides any in-flight operation. That operation's result is discarded and no done is generated.
- FSM: IDLE -> CALC -> FINISH -> IDLE.
- IDLE:
  - start=1 at edge t0: latch op, src_a and src_b, then go to CALC.
  - Signed ops latch the operand magnitudes plus sign flags: result sign = a^b for the product and quotient; remainder sign = sign of a.
- CALC: exactly ITER cycles (t0+1 .. t0+ITER); counter runs 0..ITER-1.
  - Multiply: shift-add, one multiplier bit per cycle.
  - Divide: restoring division, one quotient bit per cycle.
- FINISH: one cycle (t0+ITER+1). Apply two's-complement sign correction.
  - Only the register matching the op class is written. The other result register is untouched.
  - The write lands at the edge ending FINISH.
- done=1 and busy=0 in cycle t0+ITER+2 (t0+34 for DATA_W=32), coincident with the new result value. done is 0 in all other cycles.
- busy=1 from t0+1 through t0+ITER+1.
- A start asserted in the done cycle is accepted, giving back-to-back operations with no gap cycle.
- start while busy=1 is ignored; op and source changes while busy have no effect.
- Divide by zero (src_b=0), both DIV and DIVU: quotient = all ones, remainder = src_a unchanged. Same latency.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- Magnitude arithmetic is DATA_W+1 bits wide, so |-2^31| is representable internally.
- Unknown op values cannot occur: all 4 codes are defined.

Decomposition:
- Package mdu_pkg holds:
  - op constants OP_MULT=2'b00, OP_MULTU=2'b01, OP_DIV=2'b10, OP_DIVU=2'b11;
  - the FSM state type (IDLE, CALC, FINISH);
  - a helper is_div(op) = op[1].
- One natural sub-module, mdu_iter_core: the unsigned shared shift-register datapath, performing one add-or-subtract step per cycle.
- The top module holds the FSM, sign handling, special cases and result registers.

Test Plan:
- Unsigned max multiply: MULTU a=0xFFFFFFFF, b=0xFFFFFFFF, start at t0 -> busy high t0+1..t0+33; done at t0+34; mul_result=0xFFFFFFFE_00000001; div_result unchanged (0).
- Signed multiply: MULT a=0xFFFFFFFD (-3), b=7 -> mul_result=0xFFFFFFFF_FFFFFFEB. Then DIVU 100/7 -> div_result=0x00000002_0000000E, with mul_result still 0xFFFFFFFF_FFFFFFEB.
- Signed divide: DIV a=0xFFFFFFF9 (-7), b=2 -> div_result=0xFFFFFFFF_FFFFFFFD.
- Special cases:
  - DIVU 100/0 -> div_result=0x00000064_FFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF -> div_result=0x00000000_80000000.
- Handshake:
  - start pulsed again at t0+5 with different operands -> ignored; result matches the first op.
  - start in the done cycle -> second done exactly 34 cycles later.
- Reset mid-operation: rst=1 at t0+10 of a MULTU -> next cycle busy=0, done=0, both results 0; no done pulse for the aborted op. A new op afterwards completes normally.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the sequential multiply/divide unit.
//   - op codes for the four operations
//   - FSM state encoding (IDLE -> CALC -> FINISH)
//   - is_div(): op class helper (divide ops have op[1] set)
package mdu_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_CALC   = 2'd1;
   localparam state_t ST_FINISH = 2'd2;

   function automatic logic is_div(input logic [1:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// mdu_iter_core: unsigned shift-register datapath shared by multiply and divide.
// One add (multiply) or trial subtract (divide) per step cycle.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   load       capture lo_init/m_init and clear the upper register
//   step       perform one iteration
//   div_mode   1 = restoring divide step, 0 = shift-add multiply step
//   lo_init    multiplier (multiply) or dividend (divide) magnitude
//   m_init     multiplicand (multiply) or divisor (divide) magnitude
//   hi, lo     multiply: {product[63:32], product[31:0]}
//              divide:   {remainder, quotient}
module mdu_iter_core #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              step,
   input  logic              div_mode,
   input  logic [DATA_W-1:0] lo_init,
   input  logic [DATA_W-1:0] m_init,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo
);

   // Upper register is one bit wider so the shifted partial remainder
   // never loses its top bit before the trial subtract.
   logic [DATA_W:0]   hi_q;
   logic [DATA_W-1:0] lo_q;
   logic [DATA_W-1:0] m_q;

   logic [DATA_W:0]   sum;
   logic [DATA_W+1:0] shifted;
   logic [DATA_W:0]   diff;
   logic              ge;

   always_comb begin
      // Multiply: add multiplicand when the current multiplier bit is set;
      // the carry drops into the top of the shifted product.
      sum     = {1'b0, hi_q[DATA_W-1:0]} + (lo_q[0] ? {1'b0, m_q} : '0);
      // Divide: bring in the next dividend bit, then trial-subtract.
      shifted = {hi_q, lo_q[DATA_W-1]};
      ge      = (shifted >= {2'b00, m_q});
      diff    = shifted[DATA_W:0] - {1'b0, m_q};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q <= '0;
         lo_q <= '0;
         m_q  <= '0;
      end else if (load) begin
         hi_q <= '0;
         lo_q <= lo_init;
         m_q  <= m_init;
      end else if (step) begin
         if (div_mode) begin
            hi_q <= ge ? diff : shifted[DATA_W:0];
            lo_q <= {lo_q[DATA_W-2:0], ge};
         end else begin
            hi_q <= {1'b0, sum[DATA_W:1]};
            lo_q <= {sum[0], lo_q[DATA_W-1:1]};
         end
      end
   end

   assign hi = hi_q[DATA_W-1:0];
   assign lo = lo_q;

endmodule

// File: rtl/seq_mul_div.sv
// seq_mul_div: iterative 32-bit multiply/divide unit for the execute stage.
// Holds the FSM, sign handling, special cases and the two result registers.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   start        request an operation (sampled only while busy=0)
//   op           MULT / MULTU / DIV / DIVU (see mdu_pkg)
//   src_a        multiplicand / dividend
//   src_b        multiplier / divisor
//   busy         operation in progress
//   done         one-cycle pulse, new result visible this cycle
//   mul_result   {hi, lo} of last completed multiply
//   div_result   {remainder, quotient} of last completed divide
//
// Handshake: start is accepted at any rising edge where busy=0 (including
// the done cycle, which allows back-to-back operations). busy stays high
// for ITER+1 cycles after acceptance; done then pulses for exactly one
// cycle while busy is low, coincident with the updated result register.
module seq_mul_div
   import mdu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ITER   = DATA_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [1:0]          op,
   input  logic [DATA_W-1:0]   src_a,
   input  logic [DATA_W-1:0]   src_b,
   output logic                busy,
   output logic                done,
   output logic [2*DATA_W-1:0] mul_result,
   output logic [2*DATA_W-1:0] div_result
);

   localparam int CNT_W = $clog2(ITER);

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic              div_q;
   logic              neg_res;
   logic              neg_rem;
   logic              div_zero;
   logic [DATA_W-1:0] a_raw;

   logic              load;
   logic              a_neg;
   logic              b_neg;
   logic [DATA_W-1:0] a_mag;
   logic [DATA_W-1:0] b_mag;
   logic [DATA_W-1:0] core_hi;
   logic [DATA_W-1:0] core_lo;

   logic [2*DATA_W-1:0] prod_fix;
   logic [DATA_W-1:0]   quo_fix;
   logic [DATA_W-1:0]   rem_fix;

   assign load = (state == ST_IDLE) && start;
   assign busy = (state != ST_IDLE);

   // Signed ops (op[0]=0) work on magnitudes. The unsigned negate of
   // 0x80000000 is 2^31, which the unsigned core handles exactly.
   always_comb begin
      a_neg = ~op[0] & src_a[DATA_W-1];
      b_neg = ~op[0] & src_b[DATA_W-1];
      a_mag = a_neg ? -src_a : src_a;
      b_mag = b_neg ? -src_b : src_b;
   end

   mdu_iter_core #(.DATA_W(DATA_W)) u_core (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .step     (state == ST_CALC),
      .div_mode (div_q),
      .lo_init  (is_div(op) ? a_mag : b_mag),
      .m_init   (is_div(op) ? b_mag : a_mag),
      .hi       (core_hi),
      .lo       (core_lo)
   );

   // Sign correction and divide-by-zero override, consumed in FINISH.
   always_comb begin
      prod_fix = {core_hi, core_lo};
      if (neg_res) prod_fix = -{core_hi, core_lo};
      quo_fix = neg_res ? -core_lo : core_lo;
      rem_fix = neg_rem ? -core_hi : core_hi;
      if (div_zero) begin
         quo_fix = '1;
         rem_fix = a_raw;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         div_q      <= 1'b0;
         neg_res    <= 1'b0;
         neg_rem    <= 1'b0;
         div_zero   <= 1'b0;
         a_raw      <= '0;
         done       <= 1'b0;
         mul_result <= '0;
         div_result <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  div_q    <= is_div(op);
                  neg_res  <= a_neg ^ b_neg;
                  neg_rem  <= a_neg;
                  div_zero <= is_div(op) && (src_b == '0);
                  a_raw    <= src_a;
                  cnt      <= '0;
                  state    <= ST_CALC;
               end
            end
            ST_CALC: begin
               if (cnt == CNT_W'(ITER - 1)) begin
                  cnt   <= '0;
                  state <= ST_FINISH;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_FINISH: begin
               if (div_q) div_result <= {rem_fix, quo_fix};
               else       mul_result <= prod_fix;
               done  <= 1'b1;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
